// File: rtl/core_pkg.sv
// Shared types and widths for the back-end pipeline registers of the core.
package core_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic reg_write;
    logic memto_reg;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/pipe_reg.sv
// Pipeline register slice: holds on hold_i, loads all-zero bubble on bubble_i.
module pipe_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         hold_i,
  input  logic         bubble_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (bubble_i) begin
      data_d = '0;
    end else if (!hold_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with the MEM-stage data-cache handshake,
// global stall generation and a saturating stall-cycle counter.
module ex_mem_wb_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              RegWrite_EX_i,
  input  logic              MemtoReg_EX_i,
  input  logic              MemRead_EX_i,
  input  logic              MemWrite_EX_i,
  input  logic [DATA_W-1:0] ALU_result_EX_i,
  input  logic [DATA_W-1:0] rs2_data_EX_i,
  input  logic [4:0]        rd_EX_i,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              stall_o,
  output logic              RegWrite_MEM_o,
  output logic [4:0]        rd_MEM_o,
  output logic [DATA_W-1:0] ALU_result_MEM_o,
  output logic              RegWrite_WB_o,
  output logic [4:0]        rd_WB_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [CNT_W-1:0]  stall_cycles_o
);

  import core_pkg::*;

  localparam int unsigned EXM_W = CTRL_W + 2 * DATA_W + REG_ADDR_W;
  localparam int unsigned MWB_W = 2 + REG_ADDR_W + 2 * DATA_W;

  ctrl_t                  ctrl_ex;
  ctrl_t                  ctrl_mem;
  logic [EXM_W-1:0]       ex_mem_q;
  logic [DATA_W-1:0]      alu_mem;
  logic [DATA_W-1:0]      rs2_mem;
  logic [REG_ADDR_W-1:0]  rd_mem;
  logic                   mem_op;
  logic [DATA_W-1:0]      load_data_mem;
  logic [MWB_W-1:0]       mem_wb_q;
  logic                   reg_write_wb;
  logic                   memto_reg_wb;
  logic [REG_ADDR_W-1:0]  rd_wb;
  logic [DATA_W-1:0]      alu_wb;
  logic [DATA_W-1:0]      load_data_wb;
  state_e                 state_d;
  state_e                 state_q;
  logic [CNT_W-1:0]       stall_cycles_d;
  logic [CNT_W-1:0]       stall_cycles_q;

  always_comb begin
    ctrl_ex           = '0;
    ctrl_ex.reg_write = RegWrite_EX_i;
    ctrl_ex.memto_reg = MemtoReg_EX_i;
    ctrl_ex.mem_read  = MemRead_EX_i;
    ctrl_ex.mem_write = MemWrite_EX_i;
  end

  pipe_reg #(.W(EXM_W)) u_ex_mem (
    .clk_i    (clk_i),
    .rst_ni   (rst_i),
    .hold_i   (stall_o),
    .bubble_i (1'b0),
    .d_i      ({ctrl_ex, ALU_result_EX_i, rs2_data_EX_i, rd_EX_i}),
    .q_o      (ex_mem_q)
  );

  assign ctrl_mem = ctrl_t'(ex_mem_q[EXM_W-1 -: CTRL_W]);
  assign alu_mem  = ex_mem_q[REG_ADDR_W + 2*DATA_W - 1 -: DATA_W];
  assign rs2_mem  = ex_mem_q[REG_ADDR_W + DATA_W - 1 -: DATA_W];
  assign rd_mem   = ex_mem_q[REG_ADDR_W-1:0];

  // Cache request is driven straight from EX/MEM, so it stays stable while stalled.
  assign mem_op      = ctrl_mem.mem_read | ctrl_mem.mem_write;
  assign stall_o     = mem_op & ~mem_ack_i;
  assign mem_req_o   = mem_op;
  assign mem_we_o    = ctrl_mem.mem_write;
  assign mem_addr_o  = alu_mem;
  assign mem_wdata_o = rs2_mem;

  assign RegWrite_MEM_o   = ctrl_mem.reg_write;
  assign rd_MEM_o         = rd_mem;
  assign ALU_result_MEM_o = alu_mem;

  assign load_data_mem = ctrl_mem.mem_read ? mem_rdata_i : '0;

  // A stalled MEM stage hands WB a bubble so the older instruction retires once.
  pipe_reg #(.W(MWB_W)) u_mem_wb (
    .clk_i    (clk_i),
    .rst_ni   (rst_i),
    .hold_i   (1'b0),
    .bubble_i (stall_o),
    .d_i      ({ctrl_mem.reg_write, ctrl_mem.memto_reg, rd_mem, alu_mem, load_data_mem}),
    .q_o      (mem_wb_q)
  );

  assign reg_write_wb = mem_wb_q[MWB_W-1];
  assign memto_reg_wb = mem_wb_q[MWB_W-2];
  assign rd_wb        = mem_wb_q[2*DATA_W + REG_ADDR_W - 1 -: REG_ADDR_W];
  assign alu_wb       = mem_wb_q[2*DATA_W - 1 -: DATA_W];
  assign load_data_wb = mem_wb_q[DATA_W-1:0];

  assign RegWrite_WB_o = reg_write_wb;
  assign rd_WB_o       = rd_wb;
  assign wb_data_o     = memto_reg_wb ? load_data_wb : alu_wb;

  // Observational wait-state tracker; mirrors stall_o one cycle later.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (mem_op && !mem_ack_i) state_d = BUSY;
      BUSY:    if (mem_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_o && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q        <= IDLE;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Bench for ex_mem_wb_pipe: ALU vector table, cache-wait sequences, reset and counter saturation.
module tb_ex_mem_wb_pipe;

  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        RegWrite_EX_i, MemtoReg_EX_i, MemRead_EX_i, MemWrite_EX_i;
  logic [31:0] ALU_result_EX_i, rs2_data_EX_i, mem_rdata_i;
  logic [4:0]  rd_EX_i;
  logic        mem_ack_i;

  logic        mem_req_o, mem_we_o, stall_o, RegWrite_MEM_o, RegWrite_WB_o;
  logic [31:0] mem_addr_o, mem_wdata_o, ALU_result_MEM_o, wb_data_o;
  logic [4:0]  rd_MEM_o, rd_WB_o;
  logic [31:0] stall_cycles_o;

  logic        mem_req_4, mem_we_4, stall_4, rw_mem_4, rw_wb_4;
  logic [31:0] addr_4, wdata_4, alu_mem_4, wb_data_4;
  logic [4:0]  rd_mem_4, rd_wb_4;
  logic [3:0]  stall_cycles_4;

  ex_mem_wb_pipe #(.DATA_W(32), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .RegWrite_EX_i(RegWrite_EX_i), .MemtoReg_EX_i(MemtoReg_EX_i),
    .MemRead_EX_i(MemRead_EX_i), .MemWrite_EX_i(MemWrite_EX_i),
    .ALU_result_EX_i(ALU_result_EX_i), .rs2_data_EX_i(rs2_data_EX_i), .rd_EX_i(rd_EX_i),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .stall_o(stall_o),
    .RegWrite_MEM_o(RegWrite_MEM_o), .rd_MEM_o(rd_MEM_o), .ALU_result_MEM_o(ALU_result_MEM_o),
    .RegWrite_WB_o(RegWrite_WB_o), .rd_WB_o(rd_WB_o), .wb_data_o(wb_data_o),
    .stall_cycles_o(stall_cycles_o)
  );

  ex_mem_wb_pipe #(.DATA_W(32), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst_i),
    .RegWrite_EX_i(RegWrite_EX_i), .MemtoReg_EX_i(MemtoReg_EX_i),
    .MemRead_EX_i(MemRead_EX_i), .MemWrite_EX_i(MemWrite_EX_i),
    .ALU_result_EX_i(ALU_result_EX_i), .rs2_data_EX_i(rs2_data_EX_i), .rd_EX_i(rd_EX_i),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .mem_req_o(mem_req_4), .mem_we_o(mem_we_4), .mem_addr_o(addr_4),
    .mem_wdata_o(wdata_4), .stall_o(stall_4),
    .RegWrite_MEM_o(rw_mem_4), .rd_MEM_o(rd_mem_4), .ALU_result_MEM_o(alu_mem_4),
    .RegWrite_WB_o(rw_wb_4), .rd_WB_o(rd_wb_4), .wb_data_o(wb_data_4),
    .stall_cycles_o(stall_cycles_4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        exp_rw_mem;
    logic [4:0]  exp_rd_mem;
    logic [31:0] exp_alu_mem;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  vec_t vecs[5];
  wb_t  sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every retiring writeback must match the oldest outstanding expectation.
  task automatic mon_wb();
    wb_t e;
    if (RegWrite_WB_o === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: got rd=%0d data=%0h want no writeback (t=%0t)",
                 rd_WB_o, wb_data_o, $time);
      end else begin
        e = sb.pop_front();
        chk("wb_rd", 64'(rd_WB_o), 64'(e.rd));
        chk("wb_data", 64'(wb_data_o), 64'(e.data));
      end
    end
  endtask

  task automatic drv(input logic rw, input logic mtr, input logic mr, input logic mw,
                     input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd);
    RegWrite_EX_i   = rw;
    MemtoReg_EX_i   = mtr;
    MemRead_EX_i    = mr;
    MemWrite_EX_i   = mw;
    ALU_result_EX_i = alu;
    rs2_data_EX_i   = rs2;
    rd_EX_i         = rd;
  endtask

  task automatic nop();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    wb_t e;
    e.rd   = rd;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic half();
    @(negedge clk);
    mon_wb();
  endtask

  task automatic rise();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      half();
      rise();
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    half();
    rst_i = 1'b1;
    rise();
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'h0000_0010, 1'b1, 5'd5,  32'h0000_0010};
    vecs[1] = '{1'b1, 5'd0,  32'h0000_0022, 1'b1, 5'd0,  32'h0000_0022};
    vecs[2] = '{1'b0, 5'd9,  32'h0000_0033, 1'b0, 5'd9,  32'h0000_0033};
    vecs[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF};
    vecs[4] = '{1'b1, 5'd12, 32'h0000_A5A5, 1'b1, 5'd12, 32'h0000_A5A5};

    nop();
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    rst_i       = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", 64'(mem_req_o), 64'(0));
    chk("rst_stall", 64'(stall_o), 64'(0));
    chk("rst_rw_mem", 64'(RegWrite_MEM_o), 64'(0));
    chk("rst_rw_wb", 64'(RegWrite_WB_o), 64'(0));
    chk("rst_wb_data", 64'(wb_data_o), 64'(0));
    chk("rst_cnt", 64'(stall_cycles_o), 64'(0));
    chk("rst_state", 64'(dut.state_q), 64'(IDLE));
    rst_i = 1'b1;
    rise();

    // ALU stream; ack held high to show it is ignored without a memory op.
    mem_ack_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drv(vecs[i].rw, 1'b0, 1'b0, 1'b0, vecs[i].alu, 32'h0, vecs[i].rd);
      if (vecs[i].rw) push(vecs[i].rd, vecs[i].alu);
      half();
      chk("alu_stall", 64'(stall_o), 64'(0));
      chk("alu_req", 64'(mem_req_o), 64'(0));
      if (i > 0) begin
        chk("alu_rw_mem", 64'(RegWrite_MEM_o), 64'(vecs[i-1].exp_rw_mem));
        chk("alu_rd_mem", 64'(rd_MEM_o), 64'(vecs[i-1].exp_rd_mem));
        chk("alu_res_mem", 64'(ALU_result_MEM_o), 64'(vecs[i-1].exp_alu_mem));
      end
      rise();
    end
    nop();
    mem_ack_i = 1'b0;
    half();
    chk("alu_rd_mem_last", 64'(rd_MEM_o), 64'(vecs[4].exp_rd_mem));
    rise();
    run(2);
    chk("alu_sb_empty", 64'(sb.size()), 64'(0));
    chk("alu_state", 64'(dut.state_q), 64'(IDLE));

    // Zero-wait load.
    drv(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd7);
    push(5'd7, 32'hDEAD);
    half();
    rise();
    nop();
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hDEAD;
    half();
    chk("zw_stall", 64'(stall_o), 64'(0));
    chk("zw_req", 64'(mem_req_o), 64'(1));
    chk("zw_we", 64'(mem_we_o), 64'(0));
    chk("zw_addr", 64'(mem_addr_o), 64'(32'h40));
    rise();
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    half();
    chk("zw_rd_wb", 64'(rd_WB_o), 64'(7));
    chk("zw_cnt", 64'(stall_cycles_o), 64'(0));
    rise();

    // Store acked on the 4th cycle in MEM.
    drv(1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'hBEEF, 5'd0);
    half();
    rise();
    nop();
    for (int k = 0; k < 4; k++) begin
      mem_ack_i = (k == 3);
      half();
      chk("st_req", 64'(mem_req_o), 64'(1));
      chk("st_we", 64'(mem_we_o), 64'(1));
      chk("st_addr", 64'(mem_addr_o), 64'(32'h80));
      chk("st_wdata", 64'(mem_wdata_o), 64'(32'hBEEF));
      chk("st_stall", 64'(stall_o), 64'(k < 3));
      chk("st_state", 64'(dut.state_q), (k == 0) ? 64'(IDLE) : 64'(BUSY));
      chk("st_bubble", 64'(RegWrite_WB_o), 64'(0));
      rise();
    end
    mem_ack_i = 1'b0;
    half();
    chk("st_state_end", 64'(dut.state_q), 64'(IDLE));
    chk("st_req_end", 64'(mem_req_o), 64'(0));
    chk("st_cnt", 64'(stall_cycles_o), 64'(3));
    chk("st_cnt4", 64'(stall_cycles_4), 64'(3));
    rise();

    // Back-to-back loads, one wait each; data on non-ack cycles is junk.
    do_reset();
    drv(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd3);
    push(5'd3, 32'h1111);
    half();
    rise();
    drv(1'b1, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 5'd4);
    push(5'd4, 32'h2222);
    mem_rdata_i = 32'hBAD0;
    half();
    chk("b2b_stall1", 64'(stall_o), 64'(1));
    chk("b2b_addr1", 64'(mem_addr_o), 64'(32'h100));
    rise();
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h1111;
    half();
    chk("b2b_ack1", 64'(stall_o), 64'(0));
    rise();
    nop();
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'hBAD1;
    half();
    chk("b2b_req2", 64'(mem_req_o), 64'(1));
    chk("b2b_addr2", 64'(mem_addr_o), 64'(32'h104));
    chk("b2b_stall2", 64'(stall_o), 64'(1));
    rise();
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h2222;
    half();
    chk("b2b_ack2", 64'(stall_o), 64'(0));
    rise();
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    half();
    chk("b2b_cnt", 64'(stall_cycles_o), 64'(2));
    rise();
    run(1);
    chk("b2b_sb_empty", 64'(sb.size()), 64'(0));

    // Reset while BUSY abandons the load.
    drv(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd9);
    half();
    rise();
    nop();
    half();
    chk("rb_stall", 64'(stall_o), 64'(1));
    rise();
    chk("rb_busy", 64'(dut.state_q), 64'(BUSY));
    #2 rst_i = 1'b0;
    #1;
    chk("rb_req", 64'(mem_req_o), 64'(0));
    chk("rb_stall0", 64'(stall_o), 64'(0));
    chk("rb_addr", 64'(mem_addr_o), 64'(0));
    chk("rb_rw_mem", 64'(RegWrite_MEM_o), 64'(0));
    chk("rb_rd_mem", 64'(rd_MEM_o), 64'(0));
    chk("rb_rw_wb", 64'(RegWrite_WB_o), 64'(0));
    chk("rb_wb_data", 64'(wb_data_o), 64'(0));
    chk("rb_cnt", 64'(stall_cycles_o), 64'(0));
    chk("rb_state", 64'(dut.state_q), 64'(IDLE));
    half();
    rise();
    half();
    rst_i = 1'b1;
    rise();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 32'h77, 32'h0, 5'd14);
    push(5'd14, 32'h77);
    run(1);
    nop();
    run(2);
    chk("rb_restart_sb", 64'(sb.size()), 64'(0));
    chk("rb_restart_stall", 64'(stall_o), 64'(0));

    // Twenty stall cycles saturate the 4-bit counter.
    do_reset();
    drv(1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 32'h1, 5'd0);
    half();
    rise();
    nop();
    run(20);
    mem_ack_i = 1'b1;
    half();
    chk("sat_cnt4", 64'(stall_cycles_4), 64'(15));
    chk("sat_cnt32", 64'(stall_cycles_o), 64'(20));
    rise();
    mem_ack_i = 1'b0;
    run(2);
    chk("final_sb_empty", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_wb_pipe.md
Name: ex_mem_wb_pipe

Overview:
- Back-end pipeline register pair of the 5-stage RISC-V core: the EX/MEM and MEM/WB registers, plus the MEM-stage data-cache handshake.
- Produces RegWrite/rd for the MEM and WB stages, which the operand-forwarding logic consumes.
- Produces forwardable MEM/WB data and the global stall_o that freezes upstream stages while a load or store waits on the data cache.

Parameters:
- DATA_W, 32, datapath width.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous active-low reset.
- RegWrite_EX_i  in  1  EX-stage register-write enable.
- MemtoReg_EX_i  in  1  EX-stage select: 1 = load data to writeback, 0 = ALU result.
- MemRead_EX_i  in  1  EX-stage load.
- MemWrite_EX_i  in  1  EX-stage store.
- ALU_result_EX_i  in  DATA_W  EX result; also the memory address.
- rs2_data_EX_i  in  DATA_W  store data, already forwarded.
- rd_EX_i  in  5  destination register.
- mem_ack_i  in  1  cache access complete this cycle.
- mem_rdata_i  in  DATA_W  load data; valid when mem_ack_i=1.
- mem_req_o  out  1  cache request.
- mem_we_o  out  1  1 = store.
- mem_addr_o  out  DATA_W  address.
- mem_wdata_o  out  DATA_W  store data.
- stall_o  out  1  freeze PC, IF/ID, ID/EX and the EX-stage inputs.
- RegWrite_MEM_o  out  1  MEM-stage write enable, to forwarding.
- rd_MEM_o  out  5  MEM-stage destination, to forwarding.
- ALU_result_MEM_o  out  DATA_W  MEM-stage forward data.
- RegWrite_WB_o  out  1  WB-stage write enable, to forwarding and the register file.
- rd_WB_o  out  5  WB-stage destination.
- wb_data_o  out  DATA_W  writeback and forward data.
- stall_cycles_o  out  CNT_W  count of cycles with stall_o=1.

Behaviour:
- Reset (rst_i=0, asynchronous): all EX/MEM and MEM/WB fields, all outputs, the FSM state and the counter are 0. State = IDLE.
- mem_op = MemRead_MEM | MemWrite_MEM, taken from the EX/MEM register.
- Cache interface outputs:
  - mem_req_o = mem_op, in both FSM states.
  - mem_we_o = MemWrite_MEM.
  - mem_addr_o = ALU_result_MEM.
  - mem_wdata_o = rs2_data_MEM.
  - All are held stable while waiting.
- stall_o = mem_op & ~mem_ack_i (combinational). A zero-wait hit (ack in the same cycle as the request) produces no stall.
- FSM:
  - IDLE -> BUSY when mem_op & ~mem_ack_i.
  - BUSY -> IDLE on mem_ack_i.
  - Otherwise the state holds.
  - The FSM is observational only (it drives no output directly) but must match stall_o: state==BUSY implies the previous cycle stalled.
- EX/MEM register:
  - stall_o=0: loads all EX inputs.
  - stall_o=1: holds.
  - No flush input; branch flushes happen upstream.
- MEM/WB register:
  - stall_o=0: loads RegWrite, rd, MemtoReg, ALU result and load data (mem_rdata_i when MemRead_MEM, else 0).
  - stall_o=1: loads a bubble (RegWrite_WB=0, rd_WB=0), so the instruction ahead still retires exactly once.
- wb_data_o = MemtoReg_WB ? load_data_WB : ALU_result_WB.
- Latency: an ALU op takes 2 cycles EX->WB. A memory op takes 2 + wait cycles.
- rd=0 passes unmodified; the consumer ignores x0.
- mem_ack_i is ignored when mem_op=0.
- A reset asserted during BUSY abandons the request; mem_req_o drops immediately.
- stall_cycles_o increments each cycle stall_o=1 and saturates at all-ones.

Decomposition:
- Shared package core_pkg:
  - DATA_W.
  - REG_ADDR_W=5.
  - FSM state enum {IDLE, BUSY}.
  - A ctrl-bundle typedef {RegWrite, MemtoReg, MemRead, MemWrite}.
- One natural sub-module: pipe_reg, a parameterised-width register with stall-hold and bubble-load enables, instantiated for EX/MEM and MEM/WB.

Test Plan:
- ALU stream, ack never needed: RegWrite_EX=1, rd=5, ALU=0x10 -> next cycle RegWrite_MEM_o=1, rd_MEM_o=5; cycle +2 RegWrite_WB_o=1, wb_data_o=0x10; stall_o stays 0.
- Zero-wait load: MemRead, MemtoReg, rd=7, addr=0x40, mem_ack_i=1 with rdata=0xDEAD in the MEM cycle -> stall_o=0, mem_req_o=1, mem_addr_o=0x40; next cycle rd_WB_o=7, wb_data_o=0xDEAD; counter=0.
- 3-cycle-wait store: MemWrite, data 0xBEEF, ack on the 4th cycle -> mem_req_o/mem_we_o/mem_wdata_o held for 4 cycles; stall_o=1 for 3 cycles; RegWrite_WB_o=0 bubbles; stall_cycles_o=3; FSM BUSY for 3 cycles then IDLE.
- Back-to-back loads, each acked after 1 wait: second request begins the cycle after the first ack; each load writes back once; stall_cycles_o=2.
- Reset mid-wait: assert rst_i=0 while BUSY -> mem_req_o, stall_o and all outputs go 0 asynchronously; counter=0; after release the pipeline restarts clean.
- Counter saturation with CNT_W=4 and 20 stall cycles -> stall_cycles_o=15.
